// File: rtl/rr_port_arbiter.sv
// Round-robin output-port arbiter: one owner holds the output until its packet
// transfers or its request is withdrawn, then the grant rotates without a bubble.
module rr_port_arbiter #(
   parameter  int NUM_REQ = 5,
   parameter  int STALL_W = 8,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               xfer,
   output logic [STALL_W-1:0] stall_cnt
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state, state_next;
   logic                 armed;
   logic [IDX_W-1:0]     ptr, ptr_next;
   logic [IDX_W-1:0]     owner_inc, start, pick_idx, idx_next;
   logic                 pick_found;
   logic [NUM_REQ-1:0]   gnt_next;
   logic                 owner_req, release_now, stall_now;
   int                   cand;

   // Valid/ready: a packet moves on an edge where the owner still requests
   // (valid) and out_ready is high (ready); neither side may wait on the other.
   assign owner_req   = req[gnt_idx];
   assign xfer        = gnt_valid & owner_req & out_ready;
   assign stall_now   = gnt_valid & owner_req & ~out_ready;
   assign release_now = ~owner_req | out_ready;
   assign owner_inc   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

   // On release the scan starts just past the owner, so the owner itself is the
   // last candidate considered (eligible, but lowest priority).
   assign start = (state == IDLE) ? ptr : owner_inc;

   // Scan downward so the final hit is the first set bit in circular order.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = (int'(start) + i) % NUM_REQ;
         if (req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      gnt_next   = gnt;
      idx_next   = gnt_idx;
      case (state)
         IDLE: begin
            if (armed && pick_found) begin
               state_next         = GRANT;
               gnt_next           = '0;
               gnt_next[pick_idx] = 1'b1;
               idx_next           = pick_idx;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_next = owner_inc;
               if (pick_found) begin
                  gnt_next           = '0;
                  gnt_next[pick_idx] = 1'b1;
                  idx_next           = pick_idx;
               end else begin
                  state_next = IDLE;
                  gnt_next   = '0;
                  idx_next   = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   // armed holds off granting on the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         ptr       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_next;
         armed     <= 1'b1;
         ptr       <= ptr_next;
         gnt       <= gnt_next;
         gnt_valid <= |gnt_next;
         gnt_idx   <= idx_next;
         if (stall_now && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: reset, fairness, backpressure,
// wrap/skip, withdrawal and stall-counter saturation.
module tb_rr_port_arbiter;

   localparam int NUM_REQ = 5;
   localparam int STALL_W = 4;
   localparam int IDX_W   = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NUM_REQ-1:0] req = '0;
   logic               out_ready = 1'b0;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic               xfer;
   logic [STALL_W-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   rr_port_arbiter #(.NUM_REQ(NUM_REQ), .STALL_W(STALL_W)) dut (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
      .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
      .xfer(xfer), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req = 5'b00100; out_ready = 1'b0;
      apply_reset();
      tick();
      checks++; if (gnt !== 5'b00000) begin errors++; $display("FAIL rst_first_edge gnt got %b exp %b", gnt, 5'b00000); end
      tick();
      checks++; if (gnt !== 5'b00100) begin errors++; $display("FAIL rst_grant gnt got %b exp %b", gnt, 5'b00100); end
      #2 rst = 1'b1;
      #1;
      checks++; if (gnt !== 5'b00000) begin errors++; $display("FAIL rst_async gnt got %b exp 00000", gnt); end
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL rst_async gnt_valid got %b exp 0", gnt_valid); end
      checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL rst_async gnt_idx got %0d exp 0", gnt_idx); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_async stall_cnt got %0d exp 0", stall_cnt); end
      checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL rst_async xfer got %b exp 0", xfer); end
      req = 5'b01000;
      tick();
      rst = 1'b0;
      tick();
      checks++; if (gnt !== 5'b00000) begin errors++; $display("FAIL rst_rel_first_edge gnt got %b exp 00000", gnt); end
      tick();
      checks++; if (gnt !== 5'b01000) begin errors++; $display("FAIL rst_rel_grant gnt got %b exp 01000", gnt); end
      checks++; if (gnt_idx !== 3'd3) begin errors++; $display("FAIL rst_rel_grant gnt_idx got %0d exp 3", gnt_idx); end
      checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL rst_rel_grant gnt_valid got %b exp 1", gnt_valid); end
      req = '0; out_ready = 1'b1;
      tick();
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL rst_to_idle gnt_valid got %b exp 0", gnt_valid); end
   endtask

   task automatic test_fairness();
      logic [NUM_REQ-1:0] exp_gnt;
      apply_reset();
      req = 5'b11111; out_ready = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         exp_gnt = '0;
         exp_gnt[i % NUM_REQ] = 1'b1;
         checks++; if (gnt_idx !== IDX_W'(i % NUM_REQ)) begin errors++; $display("FAIL fair_idx[%0d] got %0d exp %0d", i, gnt_idx, i % NUM_REQ); end
         checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL fair_gnt[%0d] got %b exp %b", i, gnt, exp_gnt); end
         checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL fair_xfer[%0d] got %b exp 1", i, xfer); end
         tick();
      end
      req = '0;
      tick();
      checks++; if (gnt !== 5'b00000) begin errors++; $display("FAIL fair_idle gnt got %b exp 00000", gnt); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      req = 5'b00010; out_ready = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++; if (gnt !== 5'b00010) begin errors++; $display("FAIL bp_hold[%0d] gnt got %b exp 00010", i, gnt); end
         checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL bp_noxfer[%0d] got %b exp 0", i, xfer); end
         tick();
      end
      checks++; if (stall_cnt !== 4'd6) begin errors++; $display("FAIL bp_stall_cnt got %0d exp 6", stall_cnt); end
      out_ready = 1'b1;
      #1;
      checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL bp_xfer got %b exp 1", xfer); end
      tick();
      req = '0;
      #1;
      checks++; if (gnt !== 5'b00010) begin errors++; $display("FAIL bp_regrant gnt got %b exp 00010", gnt); end
      checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL bp_dropped_xfer got %b exp 0", xfer); end
      checks++; if (stall_cnt !== 4'd6) begin errors++; $display("FAIL bp_stall_kept got %0d exp 6", stall_cnt); end
      tick();
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL bp_idle gnt_valid got %b exp 0", gnt_valid); end
   endtask

   task automatic test_wrap_skip();
      apply_reset();
      req = 5'b01000; out_ready = 1'b1;
      tick();
      tick();
      checks++; if (gnt_idx !== 3'd3) begin errors++; $display("FAIL wrap_first got %0d exp 3", gnt_idx); end
      req = 5'b01001;
      tick();
      checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL wrap_to0 got %0d exp 0", gnt_idx); end
      tick();
      checks++; if (gnt_idx !== 3'd3) begin errors++; $display("FAIL wrap_skip_to3 got %0d exp 3", gnt_idx); end
      tick();
      checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL wrap_again gnt got %b exp 00001", gnt); end
      req = '0;
      tick();
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle gnt_valid got %b exp 0", gnt_valid); end
   endtask

   task automatic test_withdrawal();
      apply_reset();
      req = 5'b00100; out_ready = 1'b0;
      tick();
      tick();
      checks++; if (gnt_idx !== 3'd2) begin errors++; $display("FAIL wd_owner got %0d exp 2", gnt_idx); end
      req = 5'b00101;
      tick();
      checks++; if (gnt !== 5'b00100) begin errors++; $display("FAIL wd_nonowner_ignored gnt got %b exp 00100", gnt); end
      checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL wd_stall got %0d exp 1", stall_cnt); end
      req = 5'b00001; out_ready = 1'b1;
      #1;
      checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL wd_no_xfer got %b exp 0", xfer); end
      tick();
      checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL wd_next_idx got %0d exp 0", gnt_idx); end
      checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL wd_next_gnt got %b exp 00001", gnt); end
      checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL wd_stall_kept got %0d exp 1", stall_cnt); end
      req = '0;
      tick();
   endtask

   task automatic test_saturation();
      int exp_cnt;
      apply_reset();
      req = 5'b10000; out_ready = 1'b0;
      tick();
      tick();
      checks++; if (gnt_idx !== 3'd4) begin errors++; $display("FAIL sat_owner got %0d exp 4", gnt_idx); end
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp_cnt = (i > 15) ? 15 : i;
         checks++; if (stall_cnt !== STALL_W'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt, exp_cnt); end
      end
      checks++; if (gnt !== 5'b10000) begin errors++; $display("FAIL sat_hold gnt got %b exp 10000", gnt); end
      req = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_backpressure();
      test_wrap_skip();
      test_withdrawal();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_port_arbiter.md
# rr_port_arbiter

Round-robin arbiter for one router output port: up to NUM_REQ input ports (N, E, S, W, L) request the same output, and exactly one owns it until its packet is accepted downstream. It replaces the fixed-priority per-output arbiter inside the mesh router, with one instance per output port. It provides fair, lossless, back-to-back grants and exposes a stall counter for congestion debug.

## Interface
Parameters:
- NUM_REQ, 5, number of requesting input ports (≥2); bit index = port enum (NORTH=0 … LOCAL=4)
- STALL_W, 8, width of saturating stall counter
- IDX_W, $clog2(NUM_REQ), width of grant index (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-input route intent toward this output; held high until transferred or withdrawn
- out_ready  in  1  downstream (neighbour input register) can accept a packet this cycle
- gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle
- gnt_valid  out  1  registered; 1 when any gnt bit is set
- gnt_idx  out  IDX_W  registered index of current owner; 0 when idle
- xfer  out  1  combinational: gnt_valid & req[gnt_idx] & out_ready; packet moves on this edge
- stall_cnt  out  STALL_W  registered saturating count of cycles with gnt_valid & req[gnt_idx] & !out_ready

## Operation
- State register: IDLE, GRANT. Priority pointer ptr (IDX_W bits), owner index (= gnt_idx).
- Pick function: first set bit of the candidate vector scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (circular); if the vector is empty, no pick.
- IDLE: if req != 0, register gnt = onehot(pick(req, ptr)), go to GRANT; else stay, gnt = 0.
- GRANT, xfer=1: ptr <= owner+1 (wrap NUM_REQ-1 → 0); re-arbitrate in the same edge with pick(req_next, owner+1), where req_next = req with bit owner treated as still eligible but lowest priority. If a pick exists, load the new grant (stay GRANT, no bubble); else gnt cleared, go to IDLE.
- GRANT, req[owner]=0 (withdrawn, no xfer): same as the xfer case (ptr advances, re-arbitrate among remaining req).
- GRANT, req[owner]=1, out_ready=0: hold gnt unchanged indefinitely (lossless); stall_cnt += 1, saturating at 2^STALL_W-1.
- Requests from non-owners never affect the current grant; ptr changes only on release.
- gnt is always one-hot or zero; gnt_valid == |gnt; gnt_idx consistent with gnt.
- stall_cnt clears only on rst; it does not clear on release.

## Timing
- Reset (async assert, any state): gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, stall_cnt=0, state IDLE; xfer=0 follows. Reset mid-grant drops ownership immediately; no pending-grant memory.
- Deassertion: first grant possible on the second rising edge after rst falls (first edge samples req).
- Grant latency: req sampled high at edge k in IDLE → gnt visible after edge k (1 cycle).
- Transfer occurs on the edge where xfer=1; the next owner's gnt is visible right after that same edge (zero-bubble handover).
- Single requester continuously requesting with out_ready=1: xfer every cycle, gnt stays on that requester (sole candidate).
- All NUM_REQ requesting with out_ready=1: grants rotate ptr order, each port served once per NUM_REQ transfers; worst-case wait NUM_REQ-1 transfers.
- req[owner] falling and out_ready rising in the same cycle: no xfer; treated as withdrawal.

## Test plan
- Reset/idle: rst pulse mid-GRANT with gnt=5'b00100 → gnt, gnt_valid, gnt_idx, stall_cnt all 0 asynchronously; after release req=5'b01000 → gnt=5'b01000, gnt_idx=3 one cycle later.
- Fairness: req=5'b11111 held, out_ready=1 for 10 cycles → gnt_idx sequence 0,1,2,3,4,0,1,2,3,4; xfer high every cycle.
- Backpressure: req=5'b00010, out_ready=0 for 6 cycles then 1 → gnt=5'b00010 held throughout, stall_cnt=6, xfer once, then IDLE if req dropped.
- Wrap and skip: ptr=4 after owner 3 transfers, req=5'b01001 → next gnt_idx=0, then 3.
- Withdrawal: owner 2 drops req with out_ready=0, req=5'b00101 → next grant gnt_idx=0 (ptr=3 wraps), no xfer counted.
- Saturation: STALL_W=4, 20 stalled cycles → stall_cnt=15.
